// File: rtl/vga_cpu_planar_fml_if.sv
// vga_cpu_planar_fml_if: CPU Wishbone side and FML memory side of the planar engine
interface vga_cpu_planar_fml_if;
   logic [14:0] wb_adr_i;
   logic [1:0]  wb_sel_i;
   logic [15:0] wb_dat_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic [16:0] fml_adr_o;
   logic [15:0] fml_dat_o;
   logic [1:0]  fml_sel_o;
   logic        fml_we_o;
   logic        fml_stb_o;
   logic        fml_ack_i;
   logic [15:0] fml_dat_i;
   modport slave (
      input  wb_adr_i, wb_sel_i, wb_dat_i, wb_we_i, wb_stb_i, fml_ack_i, fml_dat_i,
      output wb_dat_o, wb_ack_o, fml_adr_o, fml_dat_o, fml_sel_o, fml_we_o, fml_stb_o
   );
   modport master (
      output wb_adr_i, wb_sel_i, wb_dat_i, wb_we_i, wb_stb_i, fml_ack_i, fml_dat_i,
      input  wb_dat_o, wb_ack_o, fml_adr_o, fml_dat_o, fml_sel_o, fml_we_o, fml_stb_o
   );
endinterface

// File: rtl/vga_cpu_planar_fml.sv
// vga_cpu_planar_fml: turns one CPU word access into planar FML cycles with VGA read/write modes and latches
module vga_cpu_planar_fml (
   input  logic                 clk,
   input  logic                 rst,
   vga_cpu_planar_fml_if.slave  bus,
   input  logic [1:0]           write_mode,
   input  logic                 read_mode,
   input  logic [1:0]           read_map_select,
   input  logic [3:0]           map_mask,
   input  logic [3:0]           set_reset,
   input  logic [3:0]           enable_set_reset,
   input  logic [1:0]           raster_op,
   input  logic [2:0]           data_rotate,
   input  logic [7:0]           bit_mask,
   input  logic [3:0]           color_compare,
   input  logic [3:0]           color_dont_care
);
   localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
   logic [1:0]  state_q, state_d, plane_q, plane_d;
   logic        ack_q, we_q, rm_q, accept, last_rd;
   logic [14:0] adr_q;
   logic [1:0]  sel_q, wm_q, rms_q, rop_q;
   logic [15:0] dat_q, wb_dat_q, cmp;
   logic [3:0]  mm_q, sr_q, esr_q, cc_q, cdc_q, above;
   logic [2:0]  rot_q;
   logic [7:0]  bm_q;
   logic [15:0] latch_q [4];
   logic [15:0] latch_n [4];

   function automatic logic [1:0] low_f(input logic [3:0] m);
      return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
   endfunction

   function automatic logic [7:0] lane_f(input logic [7:0] c, input logic [7:0] l);
      logic [7:0] r, s, d, o, m;
      r = 8'({c, c} >> rot_q);
      s = {8{sr_q[plane_q]}};
      d = wm_q == 2'd2 ? {8{c[plane_q]}} : (wm_q == 2'd0 && !esr_q[plane_q]) ? r : s;
      o = rop_q == 2'd1 ? d & l : rop_q == 2'd2 ? d | l : rop_q == 2'd3 ? d ^ l : d;
      m = wm_q == 2'd3 ? r & bm_q : bm_q;
      return wm_q == 2'd1 ? l : (o & m) | (l & ~m);
   endfunction

   assign accept = state_q == IDLE && bus.wb_stb_i && !ack_q;
   assign last_rd = state_q == READ && bus.fml_ack_i && plane_q == 2'd3;
   assign above = mm_q & (4'b1110 << plane_q);
   assign bus.wb_ack_o = state_q == DONE;
   assign bus.wb_dat_o = wb_dat_q;
   assign bus.fml_stb_o = state_q == READ || state_q == WRITE;
   assign bus.fml_we_o = state_q == WRITE;
   assign bus.fml_adr_o = {adr_q, plane_q};
   assign bus.fml_sel_o = sel_q;
   assign bus.fml_dat_o = {lane_f(dat_q[15:8], latch_q[plane_q][15:8]), lane_f(dat_q[7:0], latch_q[plane_q][7:0])};

   // sequence: reads walk all planes, writes hop between enabled planes only
   always_comb begin
      state_d = state_q;
      plane_d = plane_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = !bus.wb_we_i ? READ : map_mask == 4'd0 ? DONE : WRITE;
            plane_d = bus.wb_we_i ? low_f(map_mask) : 2'd0;
         end
         READ: if (bus.fml_ack_i) begin
            plane_d = plane_q + 2'd1;
            state_d = plane_q == 2'd3 ? DONE : READ;
         end
         WRITE: if (bus.fml_ack_i) begin
            plane_d = low_f(above);
            state_d = above == 4'd0 ? DONE : WRITE;
         end
         default: state_d = IDLE;
      endcase
   end

   // latch update on read acks and colour-compare result over the updated latches
   always_comb begin
      cmp = 16'hFFFF;
      for (int p = 0; p < 4; p++) begin
         latch_n[p] = (state_q == READ && bus.fml_ack_i && plane_q == 2'(p)) ? bus.fml_dat_i : latch_q[p];
         cmp &= ~({16{cdc_q[p]}} & (latch_n[p] ^ {16{cc_q[p]}}));
      end
   end

   // state, latches, read result and request capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         plane_q <= 2'd0;
         ack_q <= 1'b0;
         we_q <= 1'b0;
         rm_q <= 1'b0;
         adr_q <= '0;
         sel_q <= '0;
         dat_q <= '0;
         wb_dat_q <= '0;
         wm_q <= '0;
         rms_q <= '0;
         rop_q <= '0;
         mm_q <= '0;
         sr_q <= '0;
         esr_q <= '0;
         cc_q <= '0;
         cdc_q <= '0;
         rot_q <= '0;
         bm_q <= '0;
         for (int p = 0; p < 4; p++) latch_q[p] <= '0;
      end else begin
         state_q <= state_d;
         plane_q <= plane_d;
         ack_q <= state_q == DONE;
         for (int p = 0; p < 4; p++) latch_q[p] <= latch_n[p];
         if (last_rd) wb_dat_q <= rm_q ? cmp : latch_n[rms_q];
         if (accept) begin
            we_q <= bus.wb_we_i;
            adr_q <= bus.wb_adr_i;
            sel_q <= bus.wb_sel_i;
            dat_q <= bus.wb_dat_i;
            wm_q <= write_mode;
            rm_q <= read_mode;
            rms_q <= read_map_select;
            mm_q <= map_mask;
            sr_q <= set_reset;
            esr_q <= enable_set_reset;
            rop_q <= raster_op;
            rot_q <= data_rotate;
            bm_q <= bit_mask;
            cc_q <= color_compare;
            cdc_q <= color_dont_care;
         end
      end
   end
endmodule
